i2c_slave: RTL



---
 rtl/i2c_slave_if.sv | 32 +++
 rtl/i2c_slave.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_if.sv
// Bus and user-side signals of the I2C target, bundled as one interface.
// The slave modport is used by i2c_slave; the master modport is for the
// environment that drives SCL/SDA and consumes the user-side strobes.
// dbg_state mirrors the target FSM state for observation.
interface i2c_slave_if #(
  parameter int REG_AW = 4
) ();
  logic              i2c_scl;
  logic              i2c_sda_in;
  logic              i2c_sda_out;
  logic              i2c_sda_out_mode;
  logic              busy;
  logic              wr_valid;
  logic [7:0]        wr_sub;
  logic [7:0]        wr_data;
  logic              done;
  logic [REG_AW-1:0] rd_sub;
  logic [7:0]        rd_data;
  logic [3:0]        dbg_state;

  modport slave (
    input  i2c_scl, i2c_sda_in, rd_sub,
    output i2c_sda_out, i2c_sda_out_mode, busy, wr_valid, wr_sub, wr_data,
           done, rd_data, dbg_state
  );

  modport master (
    output i2c_scl, i2c_sda_in, rd_sub,
    input  i2c_sda_out, i2c_sda_out_mode, busy, wr_valid, wr_sub, wr_data,
           done, rd_data, dbg_state
  );
endinterface

// File: rtl/i2c_slave.sv
// I2C target with a small byte register file addressed by a sub-address.
// SCL/SDA are oversampled on clk (2-FF sync + previous-value register), so
// every bus event acts 3 clk after the pin change. SCL is never driven.
// Handshake: wr_valid is a one-clk strobe with no backpressure; wr_sub and
// wr_data are valid in that clk. done is a one-clk strobe on the STOP that
// ends an addressed transaction. rd_data = regs[rd_sub] one clk later.
// Optional feature: define I2C_SLAVE_AUTO_INC_EN to advance the pointer after
// every data byte (write ACK and master read ACK); otherwise it stays put.
module i2c_slave #(
  parameter logic [6:0] DEV_ADDR = 7'b1101000,
  parameter int         REG_AW   = 4
) (
  input logic        clk,
  input logic        reset,
  i2c_slave_if.slave bus
);

`ifdef I2C_SLAVE_AUTO_INC_EN
  localparam bit AUTO_INC = 1'b1;
`else
  localparam bit AUTO_INC = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    SUB       = 4'd3,
    SUB_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RACK      = 4'd8,
    WAIT_STOP = 4'd9
  } state_t;

  state_t            state, state_n;
  logic              scl_s1, scl_s2, scl_q, sda_s1, sda_s2, sda_q;
  logic              scl_rise, scl_fall, start_ev, stop_ev;
  logic [3:0]        bit_cnt, bit_cnt_n;
  logic [7:0]        shreg, shreg_n, ptr, ptr_n;
  logic              rw, rw_n, ack_on, ack_on_n;
  logic              sda_out, sda_out_n, sda_mode, sda_mode_n;
  logic              busy, busy_n, wr_valid, wr_valid_n, done, done_n;
  logic [7:0]        wr_sub, wr_sub_n, wr_data, wr_data_n;
  logic              reg_we;
  logic [7:0]        regs [2**REG_AW];
  logic [7:0]        byte_in, rd_byte;

  assign scl_rise = scl_s2 & ~scl_q;
  assign scl_fall = ~scl_s2 & scl_q;
  assign start_ev = scl_s2 & scl_q & sda_q & ~sda_s2;
  assign stop_ev  = scl_s2 & scl_q & ~sda_q & sda_s2;
  assign byte_in  = {shreg[6:0], sda_s2};
  assign rd_byte  = regs[ptr[REG_AW-1:0]];

  // Synchronize the raw bus pins and keep the previous value for edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      {scl_s1, scl_s2, scl_q} <= 3'b111;
      {sda_s1, sda_s2, sda_q} <= 3'b111;
    end else begin
      {scl_s1, scl_s2, scl_q} <= {bus.i2c_scl, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_q} <= {bus.i2c_sda_in, sda_s1, sda_s2};
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state and datapath updates; STOP/START override every state.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    ptr_n      = ptr;
    rw_n       = rw;
    ack_on_n   = ack_on;
    sda_out_n  = sda_out;
    sda_mode_n = sda_mode;
    busy_n     = busy;
    wr_valid_n = 1'b0;
    wr_sub_n   = wr_sub;
    wr_data_n  = wr_data;
    done_n     = 1'b0;
    reg_we     = 1'b0;
    if (stop_ev) begin
      state_n    = IDLE;
      sda_out_n  = 1'b1;
      sda_mode_n = 1'b0;
      busy_n     = 1'b0;
      done_n     = busy;
      ack_on_n   = 1'b0;
    end else if (start_ev) begin
      state_n    = ADDR;
      bit_cnt_n  = 4'd0;
      sda_out_n  = 1'b1;
      sda_mode_n = 1'b0;
      busy_n     = 1'b0;
      ack_on_n   = 1'b0;
    end else begin
      case (state)
        ADDR, SUB, WDATA: if (scl_rise) begin
          shreg_n   = byte_in;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt_n = 4'd0;
            if (state == SUB) begin
              ptr_n    = byte_in;
              state_n  = SUB_ACK;
            end else if (state == WDATA) begin
              state_n  = WDATA_ACK;
            end else if (byte_in[7:1] == DEV_ADDR) begin
              rw_n     = byte_in[0];
              state_n  = ADDR_ACK;
            end else begin
              state_n  = WAIT_STOP;
            end
          end
        end
        ADDR_ACK, SUB_ACK, WDATA_ACK: if (scl_fall) begin
          if (!ack_on) begin
            // First fall after the 8th bit: pull SDA low for the ACK.
            ack_on_n   = 1'b1;
            sda_out_n  = 1'b0;
            sda_mode_n = 1'b1;
            if (state == ADDR_ACK) busy_n = 1'b1;
            if (state == WDATA_ACK) begin
              reg_we     = 1'b1;
              wr_valid_n = 1'b1;
              wr_sub_n   = ptr;
              wr_data_n  = shreg;
            end
          end else begin
            // Second fall: end of ACK slot.
            ack_on_n   = 1'b0;
            bit_cnt_n  = 4'd0;
            sda_out_n  = 1'b1;
            sda_mode_n = 1'b0;
            if (state == ADDR_ACK && rw) begin
              // First read bit is driven on this same fall.
              state_n    = RDATA;
              sda_out_n  = rd_byte[7];
              sda_mode_n = 1'b1;
              shreg_n    = {rd_byte[6:0], 1'b0};
            end else if (state == ADDR_ACK) begin
              state_n = SUB;
            end else begin
              state_n = WDATA;
              if (state == WDATA_ACK && AUTO_INC) ptr_n = ptr + 8'd1;
            end
          end
        end
        RDATA: begin
          // bit_cnt counts rises; 9 means "load a fresh byte on next fall".
          if (scl_rise && bit_cnt < 4'd8) bit_cnt_n = bit_cnt + 4'd1;
          if (scl_fall) begin
            if (bit_cnt == 4'd9) begin
              bit_cnt_n  = 4'd0;
              sda_out_n  = rd_byte[7];
              sda_mode_n = 1'b1;
              shreg_n    = {rd_byte[6:0], 1'b0};
            end else if (bit_cnt == 4'd8) begin
              bit_cnt_n  = 4'd0;
              sda_out_n  = 1'b1;
              sda_mode_n = 1'b0;
              state_n    = RACK;
            end else begin
              sda_out_n  = shreg[7];
              shreg_n    = {shreg[6:0], 1'b0};
            end
          end
        end
        RACK: if (scl_rise) begin
          if (!sda_s2) begin
            state_n   = RDATA;
            bit_cnt_n = 4'd9;
            if (AUTO_INC) ptr_n = ptr + 8'd1;
          end else begin
            state_n   = WAIT_STOP;
          end
        end
        IDLE, WAIT_STOP: ;
        default: state_n = IDLE;
      endcase
    end
  end

  // Datapath registers, register file and registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt  <= 4'd0;
      shreg    <= 8'd0;
      ptr      <= 8'd0;
      rw       <= 1'b0;
      ack_on   <= 1'b0;
      sda_out  <= 1'b1;
      sda_mode <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_sub   <= 8'd0;
      wr_data  <= 8'd0;
      done     <= 1'b0;
      bus.rd_data <= 8'd0;
      for (int i = 0; i < 2**REG_AW; i++) regs[i] <= 8'd0;
    end else begin
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      ptr      <= ptr_n;
      rw       <= rw_n;
      ack_on   <= ack_on_n;
      sda_out  <= sda_out_n;
      sda_mode <= sda_mode_n;
      busy     <= busy_n;
      wr_valid <= wr_valid_n;
      wr_sub   <= wr_sub_n;
      wr_data  <= wr_data_n;
      done     <= done_n;
      bus.rd_data <= regs[bus.rd_sub];
      if (reg_we) regs[ptr[REG_AW-1:0]] <= shreg;
    end
  end

  assign bus.i2c_sda_out      = sda_out;
  assign bus.i2c_sda_out_mode = sda_mode;
  assign bus.busy             = busy;
  assign bus.wr_valid         = wr_valid;
  assign bus.wr_sub           = wr_sub;
  assign bus.wr_data          = wr_data;
  assign bus.done             = done;
  assign bus.dbg_state        = state;

endmodule
